// File: rtl/id_stage.sv
// id_stage: MIPS-style instruction decode stage with register file, control decode and ID/EX register
// Optional feature macro: ID_LOAD_USE_STALL_EN (load-use hazard detection, bubble insertion, stall counter).
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   if_id                 : IF/ID register, [63:32] PC+4, [31:0] instruction
//   wb_reg_write/_reg/_data : write-back port into the register file
//   ex_mem_read, ex_rt    : load-use hazard inputs from the EX stage
//   flush                 : branch taken, squash the instruction in ID
//   out_*                 : registered ID/EX fields (control groups and datapath)
//   stall                 : combinational, upstream holds PC and IF/ID
//   stall_count           : saturating count of stall bubbles
module id_stage #(
    parameter int RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] if_id,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        flush,
    output logic [1:0]  out_WB,
    output logic [2:0]  out_M,
    output logic [3:0]  out_EX,
    output logic [31:0] out_incremented_PC,
    output logic [31:0] out_regData1,
    output logic [31:0] out_regData2,
    output logic [31:0] out_sign_extended_offset,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic        stall,
    output logic [15:0] stall_count
);
    logic [31:0] rf [RF_DEPTH];
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctl;
    logic [31:0] rd1, rd2, sext;
    assign op   = if_id[31:26];
    assign rs   = if_id[25:21];
    assign rt   = if_id[20:16];
    assign rd   = if_id[15:11];
    assign sext = {{16{if_id[15]}}, if_id[15:0]};
    // {WB[1:0], M[2:0], EX[3:0]}
    always_comb begin
        ctl = op == 6'b000000 ? 9'b10_000_1010 :
              op == 6'b100011 ? 9'b11_010_0001 :
              op == 6'b101011 ? 9'b00_001_0001 :
              op == 6'b000100 ? 9'b00_100_0100 :
              op == 6'b001000 ? 9'b10_000_0001 : 9'b0;
    end
    // write-through: a register written this cycle is read with its new value
    always_comb begin
        rd1 = rs == 5'd0 ? 32'd0 : (wb_reg_write && wb_write_reg == rs) ? wb_write_data : rf[rs];
        rd2 = rt == 5'd0 ? 32'd0 : (wb_reg_write && wb_write_reg == rt) ? wb_write_data : rf[rt];
    end
`ifdef ID_LOAD_USE_STALL_EN
    logic uses_rt, hazard;
    assign uses_rt = op == 6'b000000 || op == 6'b101011 || op == 6'b000100;
    assign hazard  = ex_mem_read && ex_rt != 5'd0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
    // flush wins over stall, and nothing stalls during reset
    assign stall   = hazard && !flush && !reset;
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= 16'd0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`else
    logic unused_hazard;
    assign unused_hazard = ^{ex_mem_read, ex_rt};
    assign stall         = 1'b0;
    assign stall_count   = 16'd0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++)
                rf[i] <= 32'd0;
            {out_WB, out_M, out_EX}  <= 9'd0;
            out_incremented_PC       <= 32'd0;
            out_regData1             <= 32'd0;
            out_regData2             <= 32'd0;
            out_sign_extended_offset <= 32'd0;
            out_rt                   <= 5'd0;
            out_rd                   <= 5'd0;
        end else begin
            if (wb_reg_write && wb_write_reg != 5'd0)
                rf[wb_write_reg] <= wb_write_data;
            {out_WB, out_M, out_EX}  <= (stall || flush) ? 9'd0 : ctl;
            out_incremented_PC       <= if_id[63:32];
            out_regData1             <= rd1;
            out_regData2             <= rd2;
            out_sign_extended_offset <= sext;
            out_rt                   <= rt;
            out_rd                   <= rd;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized scoreboard bench for id_stage against a behavioural register/decode model
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_id;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        flush;
    logic [1:0]  out_WB;
    logic [2:0]  out_M;
    logic [3:0]  out_EX;
    logic [31:0] out_incremented_PC, out_regData1, out_regData2, out_sign_extended_offset;
    logic [4:0]  out_rt, out_rd;
    logic        stall;
    logic [15:0] stall_count;

    id_stage dut (
        .clk(clk), .reset(reset), .if_id(if_id),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
        .out_WB(out_WB), .out_M(out_M), .out_EX(out_EX),
        .out_incremented_PC(out_incremented_PC), .out_regData1(out_regData1),
        .out_regData2(out_regData2), .out_sign_extended_offset(out_sign_extended_offset),
        .out_rt(out_rt), .out_rd(out_rd), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        care;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] pc, r1, r2, se;
        logic [4:0]  rt, rd;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs [32];
    int          cnt_m = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input int s, input int t, input int d);
        logic [4:0] a = 5'(s), b = 5'(t), c = 5'(d);
        return {6'd0, a, b, c, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
        logic [4:0] a = 5'(s), b = 5'(t);
        return {o, a, b, imm};
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] r, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && wr == r) return wd;
        return regs[r];
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic mr, input logic [4:0] ert, input logic fl);
        exp_t       e;
        logic [31:0] pc4 = $urandom;
        logic [5:0] op = ins[31:26];
        logic [4:0] s = ins[25:21], t = ins[20:16];
        logic [8:0] c;
        logic       haz;
        reset = r; if_id = {pc4, ins}; wb_reg_write = we; wb_write_reg = wr;
        wb_write_data = wd; ex_mem_read = mr; ex_rt = ert; flush = fl;
        case (op)
            6'd0:  c = 9'b10_000_1010;
            6'd35: c = 9'b11_010_0001;
            6'd43: c = 9'b00_001_0001;
            6'd4:  c = 9'b00_100_0100;
            6'd8:  c = 9'b10_000_0001;
            default: c = 9'd0;
        endcase
`ifdef ID_LOAD_USE_STALL_EN
        haz = mr && ert != 0 && (ert == s || ((op == 0 || op == 43 || op == 4) && ert == t));
`else
        haz = 1'b0;
`endif
        e.st = haz && !fl && !r;
        if (r) begin
            e.care = 1'b1; {e.wb, e.m, e.ex} = 9'd0;
            e.pc = 0; e.r1 = 0; e.r2 = 0; e.se = 0; e.rt = 0; e.rd = 0; e.cnt = 0;
            foreach (regs[i]) regs[i] = 32'd0;
            cnt_m = 0;
        end else begin
            e.care = !e.st;
            {e.wb, e.m, e.ex} = (e.st || fl) ? 9'd0 : c;
            e.pc = pc4; e.r1 = rdval(s, we, wr, wd); e.r2 = rdval(t, we, wr, wd);
            e.se = {{16{ins[15]}}, ins[15:0]}; e.rt = t; e.rd = ins[15:11];
            if (e.st && cnt_m < 16'hFFFF) cnt_m++;
            e.cnt = 16'(cnt_m);
            if (we && wr != 0) regs[wr] = wd;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic s;
        forever begin
            @(posedge clk);
            s = stall;
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall", 32'(s), 32'(e.st));
                chk("out_WB", 32'(out_WB), 32'(e.wb));
                chk("out_M", 32'(out_M), 32'(e.m));
                chk("out_EX", 32'(out_EX), 32'(e.ex));
                chk("stall_count", 32'(stall_count), 32'(e.cnt));
                if (e.care) begin
                    chk("out_incremented_PC", out_incremented_PC, e.pc);
                    chk("out_regData1", out_regData1, e.r1);
                    chk("out_regData2", out_regData2, e.r2);
                    chk("out_sign_extended_offset", out_sign_extended_offset, e.se);
                    chk("out_rt", 32'(out_rt), 32'(e.rt));
                    chk("out_rd", 32'(out_rd), 32'(e.rd));
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] ins;
        logic [4:0]  ert;
        logic [5:0]  ops [7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd13, 6'd2};
        step(1, 32'h0, 1, 5'd9, 32'hDEAD, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 5'd5, 32'hAA, 0, 0, 0);
        step(0, rtype(5, 0, 3), 0, 0, 0, 0, 0, 0);
        step(0, itype(6'd43, 0, 7, 16'd8), 1, 5'd7, 32'h1234, 0, 0, 0);
        step(0, rtype(4, 1, 2), 0, 0, 0, 1, 5'd4, 0);
        step(0, rtype(4, 1, 2), 0, 0, 0, 0, 0, 0);
        step(0, rtype(0, 0, 2), 0, 0, 0, 1, 5'd0, 0);
        step(0, rtype(4, 1, 2), 0, 0, 0, 1, 5'd4, 1);
        step(0, itype(6'd35, 2, 1, 16'hFFFC), 0, 0, 0, 0, 0, 0);
        step(0, itype(6'd8, 5, 6, 16'h7FFF), 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd6, 0);
        step(0, itype(6'd35, 0, 0, 16'd1), 0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 5'd5, 32'h55, 0, 0, 0);
        step(1, rtype(5, 7, 1), 1, 5'd8, 32'h77, 0, 0, 0);
        step(0, rtype(5, 8, 1), 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0: ert = ins[25:21];
                1: ert = ins[20:16];
                2: ert = 5'd0;
                default: ert = 5'($urandom);
            endcase
            step($urandom_range(0, 49) == 0, ins, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), ert, $urandom_range(0, 7) == 0);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
